// File: rtl/decode_stage_pipe_pkg.sv
// Shared definitions for the decode stage: widths, decoded-bundle layout,
// opcode constants and the squash state encoding.
package decode_stage_pipe_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned DEC_W_DEF = 39;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned IMM_W     = 16;

    // Bit offsets of the fields inside the packed decoded bundle
    localparam int unsigned DEC_IMM_LSB   = 0;
    localparam int unsigned DEC_RT_LSB    = 16;
    localparam int unsigned DEC_RS_LSB    = 21;
    localparam int unsigned DEC_RD_LSB    = 26;
    localparam int unsigned DEC_USE_IMM   = 31;
    localparam int unsigned DEC_MEM_WRITE = 32;
    localparam int unsigned DEC_MEM_READ  = 33;
    localparam int unsigned DEC_REG_WRITE = 34;
    localparam int unsigned DEC_ALU_LSB   = 35;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        ALU_NOP = 4'h0,
        ALU_ADD = 4'h1,
        ALU_SUB = 4'h2,
        ALU_AND = 4'h3,
        ALU_OR  = 4'h4
    } alu_op_e;

    typedef struct packed {
        alu_op_e             alu_op;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                use_imm;
        logic [REG_AW-1:0]   rd;
        logic [REG_AW-1:0]   rs;
        logic [REG_AW-1:0]   rt;
        logic [IMM_W-1:0]    imm;
    } dec_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;

endpackage

// File: rtl/decode_hazard_unit.sv
// Load-use hazard detect against the EX-stage load, plus saturating stall-cycle counter.
module decode_hazard_unit
    import decode_stage_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_load_valid_i,
    input  logic [REG_AW-1:0] ex_load_rd_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic              cnt_en_i,
    output logic              hazard_c_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    // r0 is hardwired zero, so a load targeting it never blocks a reader
    assign hazard_c_o = ex_load_valid_i && (ex_load_rd_i != '0) &&
                        ((ex_load_rd_i == rs_i) || (ex_load_rd_i == rt_i));

    always_comb begin
        stall_d = stall_q;
        if (hazard_c_o && cnt_en_i && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;

endmodule

// File: rtl/i_decoder.sv
// Combinational instruction decoder: fetched word to packed control bundle.
module i_decoder
    import decode_stage_pipe_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output dec_t               dec_o
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    always_comb begin
        dec_o     = '0;
        dec_o.rs  = instr_i[25:21];
        dec_o.rt  = instr_i[20:16];
        dec_o.imm = instr_i[15:0];
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin dec_o.alu_op = ALU_ADD; dec_o.reg_write = 1'b1; dec_o.rd = instr_i[15:11]; end
                    FN_SUB:  begin dec_o.alu_op = ALU_SUB; dec_o.reg_write = 1'b1; dec_o.rd = instr_i[15:11]; end
                    FN_AND:  begin dec_o.alu_op = ALU_AND; dec_o.reg_write = 1'b1; dec_o.rd = instr_i[15:11]; end
                    FN_OR:   begin dec_o.alu_op = ALU_OR;  dec_o.reg_write = 1'b1; dec_o.rd = instr_i[15:11]; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec_o.alu_op    = ALU_ADD;
                dec_o.reg_write = 1'b1;
                dec_o.use_imm   = 1'b1;
                dec_o.rd        = instr_i[20:16];
            end
            OP_LW: begin
                dec_o.alu_op    = ALU_ADD;
                dec_o.reg_write = 1'b1;
                dec_o.mem_read  = 1'b1;
                dec_o.use_imm   = 1'b1;
                dec_o.rd        = instr_i[20:16];
            end
            OP_SW: begin
                dec_o.alu_op    = ALU_ADD;
                dec_o.mem_write = 1'b1;
                dec_o.use_imm   = 1'b1;
            end
            OP_BEQ, OP_BNE: dec_o.alu_op = ALU_SUB;
            OP_JAL: begin
                dec_o.reg_write = 1'b1;
                dec_o.rd        = 5'd31;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/next_pc_calc.sv
// Combinational next-PC: sequential, conditional branch, absolute jump or register jump.
module next_pc_calc
    import decode_stage_pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    a_i,
    input  logic [XLEN-1:0]    b_i,
    output logic [XLEN-1:0]    next_pc_o
);

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] j_tgt;

    assign pc4    = pc_i + XLEN'(4);
    assign br_off = {{(XLEN-18){instr_i[15]}}, instr_i[15:0], 2'b00};
    assign j_tgt  = {pc4[XLEN-1:28], instr_i[25:0], 2'b00};

    always_comb begin
        next_pc_o = pc4;
        case (instr_i[31:26])
            OP_BEQ:        if (a_i == b_i) next_pc_o = pc4 + br_off;
            OP_BNE:        if (a_i != b_i) next_pc_o = pc4 + br_off;
            OP_J, OP_JAL:  next_pc_o = j_tgt;
            OP_RTYPE:      if (instr_i[5:0] == FN_JR) next_pc_o = a_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode pipeline stage: decodes the fetch word, computes next PC, and holds
// results in an ID/EX register with load-use interlock, redirect and squash.
module decode_stage_pipe
    import decode_stage_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned DEC_W      = DEC_W_DEF,
    parameter int unsigned DELAY_SLOT = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic [REG_AW-1:0]  rs,
    output logic [REG_AW-1:0]  rt,
    input  logic [XLEN-1:0]    a_gpr,
    input  logic [XLEN-1:0]    b_gpr,
    input  logic               ex_load_valid,
    input  logic [REG_AW-1:0]  ex_load_rd,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DEC_W-1:0]   out_decoded,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_a,
    output logic [XLEN-1:0]    out_b,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [CNT_W-1:0]   stall_cnt
);

    dec_t            dec_c;
    logic [XLEN-1:0] next_pc_c;
    logic            hazard_c;
    logic            drop_c;
    logic            take_c;
    logic            taken_c;
    logic            cnt_en_c;

    state_e          state_q,     state_d;
    logic [XLEN-1:0] tgt_q,       tgt_d;
    logic            out_valid_q, out_valid_d;
    logic [DEC_W-1:0] out_dec_q,  out_dec_d;
    logic [XLEN-1:0] out_pc_q,    out_pc_d;
    logic [XLEN-1:0] out_a_q,     out_a_d;
    logic [XLEN-1:0] out_b_q,     out_b_d;
    logic            redir_v_q,   redir_v_d;
    logic [XLEN-1:0] redir_pc_q,  redir_pc_d;

    assign rs = in_instr[25:21];
    assign rt = in_instr[20:16];

    i_decoder u_dec (
        .instr_i (in_instr),
        .dec_o   (dec_c)
    );

    next_pc_calc #(.XLEN(XLEN)) u_npc (
        .instr_i   (in_instr),
        .pc_i      (in_pc),
        .a_i       (a_gpr),
        .b_i       (b_gpr),
        .next_pc_o (next_pc_c)
    );

    decode_hazard_unit #(.CNT_W(CNT_W)) u_hz (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_load_valid_i (ex_load_valid),
        .ex_load_rd_i    (ex_load_rd),
        .rs_i            (rs),
        .rt_i            (rt),
        .cnt_en_i        (cnt_en_c),
        .hazard_c_o      (hazard_c),
        .stall_cnt_o     (stall_cnt)
    );

    // Wrong-path words are swallowed unconditionally while squashing
    assign drop_c   = (state_q == ST_SQUASH) && (in_pc != tgt_q);
    assign cnt_en_c = in_valid && !drop_c && !flush;
    assign in_ready = !flush && (drop_c || (!hazard_c && (!out_valid_q || out_ready)));
    assign take_c   = in_valid && in_ready && !drop_c;
    assign taken_c  = (next_pc_c != (in_pc + XLEN'(4)));

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        out_valid_d = out_valid_q;
        out_dec_d   = out_dec_q;
        out_pc_d    = out_pc_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        redir_v_d   = 1'b0;
        redir_pc_d  = redir_pc_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_RUN;
        end else begin
            if (take_c) begin
                out_valid_d = 1'b1;
                out_dec_d   = DEC_W'(dec_c);
                out_pc_d    = in_pc;
                out_a_d     = a_gpr;
                out_b_d     = b_gpr;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (take_c && taken_c) begin
                redir_v_d  = 1'b1;
                redir_pc_d = next_pc_c;
            end
            if (DELAY_SLOT == 0) begin
                if (take_c && taken_c) begin
                    state_d = ST_SQUASH;
                    tgt_d   = next_pc_c;
                end else if ((state_q == ST_SQUASH) && in_valid && (in_pc == tgt_q)) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            tgt_q       <= '0;
            out_valid_q <= 1'b0;
            out_dec_q   <= '0;
            out_pc_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            redir_v_q   <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            out_valid_q <= out_valid_d;
            out_dec_q   <= out_dec_d;
            out_pc_q    <= out_pc_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            redir_v_q   <= redir_v_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_decoded    = out_dec_q;
    assign out_pc         = out_pc_q;
    assign out_a          = out_a_q;
    assign out_b          = out_b_q;
    assign redirect_valid = redir_v_q;
    assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: index 0 runs delay-slot mode, index 1 squash mode,
// both fed identical stimulus and checked against a cycle-level reference model.
module tb_decode_stage_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] a_gpr;
    logic [31:0] b_gpr;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        flush;
    logic        out_ready;

    logic        irdy [2];
    logic [4:0]  rs_o [2];
    logic [4:0]  rt_o [2];
    logic        ov   [2];
    logic [38:0] od   [2];
    logic [31:0] opc  [2];
    logic [31:0] oa   [2];
    logic [31:0] ob   [2];
    logic        rv   [2];
    logic [31:0] rpc  [2];
    logic [15:0] scnt [2];

    // reference model state
    logic        m_valid [2];
    logic [38:0] m_dec   [2];
    logic [31:0] m_pc    [2];
    logic [31:0] m_a     [2];
    logic [31:0] m_b     [2];
    logic        m_rv    [2];
    logic [31:0] m_rpc   [2];
    int          m_cnt   [2];
    logic        m_sq    [2];
    logic [31:0] m_tgt   [2];
    logic        e_rdy   [2];
    logic        obs_rdy [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    decode_stage_pipe #(.XLEN(32), .DEC_W(39), .DELAY_SLOT(1), .CNT_W(16)) dut_ds (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]),
        .in_instr(in_instr), .in_pc(in_pc), .rs(rs_o[0]), .rt(rt_o[0]),
        .a_gpr(a_gpr), .b_gpr(b_gpr), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_decoded(od[0]),
        .out_pc(opc[0]), .out_a(oa[0]), .out_b(ob[0]), .redirect_valid(rv[0]),
        .redirect_pc(rpc[0]), .stall_cnt(scnt[0])
    );

    decode_stage_pipe #(.XLEN(32), .DEC_W(39), .DELAY_SLOT(0), .CNT_W(16)) dut_sq (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]),
        .in_instr(in_instr), .in_pc(in_pc), .rs(rs_o[1]), .rt(rt_o[1]),
        .a_gpr(a_gpr), .b_gpr(b_gpr), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_decoded(od[1]),
        .out_pc(opc[1]), .out_a(oa[1]), .out_b(ob[1]), .redirect_valid(rv[1]),
        .redirect_pc(rpc[1]), .stall_cnt(scnt[1])
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    // expected control bundle: {alu, reg_write, mem_read, mem_write, use_imm, dest, rs, rt, imm}
    function automatic logic [38:0] ref_dec(input logic [31:0] ins);
        int          op = int'(ins[31:26]);
        int          fn = int'(ins[5:0]);
        logic [3:0]  alu = 4'd0;
        logic [3:0]  flags = 4'b0000;
        logic [4:0]  dst = 5'd0;
        case (op)
            'h00: begin
                if (fn == 'h20 || fn == 'h22 || fn == 'h24 || fn == 'h25) begin
                    alu   = (fn == 'h20) ? 4'd1 : (fn == 'h22) ? 4'd2 : (fn == 'h24) ? 4'd3 : 4'd4;
                    flags = 4'b1000;
                    dst   = ins[15:11];
                end
            end
            'h08: begin alu = 4'd1; flags = 4'b1001; dst = ins[20:16]; end
            'h23: begin alu = 4'd1; flags = 4'b1101; dst = ins[20:16]; end
            'h2B: begin alu = 4'd1; flags = 4'b0011; end
            'h04, 'h05: alu = 4'd2;
            'h03: begin flags = 4'b1000; dst = 5'd31; end
            default: ;
        endcase
        return {alu, flags, dst, ins[25:21], ins[20:16], ins[15:0]};
    endfunction

    function automatic logic [31:0] ref_npc(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] seq = pc + 32'd4;
        int          soff = int'($signed(ins[15:0]));
        int          op = int'(ins[31:26]);
        if (op == 'h04 && a == b) return seq + 32'(soff * 4);
        if (op == 'h05 && a != b) return seq + 32'(soff * 4);
        if (op == 'h02 || op == 'h03) return (seq & 32'hF000_0000) | (32'(ins[25:0]) << 2);
        if (op == 'h00 && ins[5:0] == 6'h08) return a;
        return seq;
    endfunction

    task automatic idle();
        in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; a_gpr = 32'd0; b_gpr = 32'd0;
        ex_load_valid = 1'b0; ex_load_rd = 5'd0; flush = 1'b0; out_ready = 1'b1;
    endtask

    // one clock: evaluate the model against current inputs, sample in_ready, advance
    task automatic tick();
        logic [31:0] np;
        logic [38:0] d;
        logic        hz, tkn;
        logic [1:0]  dr, tk;
        np  = ref_npc(in_instr, in_pc, a_gpr, b_gpr);
        d   = ref_dec(in_instr);
        hz  = ex_load_valid && (ex_load_rd != 5'd0) && (ex_load_rd == in_instr[25:21] || ex_load_rd == in_instr[20:16]);
        tkn = (np != in_pc + 32'd4);
        for (int m = 0; m < 2; m++) begin
            dr[m]    = m_sq[m] && (in_pc != m_tgt[m]);
            e_rdy[m] = !flush && (dr[m] || (!hz && (!m_valid[m] || out_ready)));
            tk[m]    = in_valid && e_rdy[m] && !dr[m];
        end
        #1;
        for (int m = 0; m < 2; m++) obs_rdy[m] = irdy[m];
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_valid[m] = 1'b0; m_dec[m] = '0; m_pc[m] = '0; m_a[m] = '0; m_b[m] = '0;
                m_rv[m] = 1'b0; m_rpc[m] = '0; m_cnt[m] = 0; m_sq[m] = 1'b0; m_tgt[m] = '0;
            end else if (flush) begin
                m_valid[m] = 1'b0; m_rv[m] = 1'b0; m_sq[m] = 1'b0;
            end else begin
                if (hz && in_valid && !dr[m] && m_cnt[m] < 65535) m_cnt[m]++;
                m_rv[m] = tk[m] && tkn;
                if (tk[m] && tkn) m_rpc[m] = np;
                if (tk[m]) begin
                    m_valid[m] = 1'b1; m_dec[m] = d; m_pc[m] = in_pc; m_a[m] = a_gpr; m_b[m] = b_gpr;
                end else if (m_valid[m] && out_ready) begin
                    m_valid[m] = 1'b0;
                end
                if (m == 1) begin
                    if (tk[m] && tkn) begin
                        m_sq[m] = 1'b1; m_tgt[m] = np;
                    end else if (m_sq[m] && in_valid && in_pc == m_tgt[m]) begin
                        m_sq[m] = 1'b0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; in_valid = 1'b1; in_instr = j_type(6'h02, 26'h40); in_pc = 32'h10;
        a_gpr = $urandom; b_gpr = $urandom; ex_load_valid = 1'b1; ex_load_rd = 5'd3;
        tick(); tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (ov[m] !== 1'b0) begin errors++; $display("FAIL reset_valid m=%0d got %0b exp 0", m, ov[m]); end
            checks++; if (od[m] !== 39'd0) begin errors++; $display("FAIL reset_dec m=%0d got %h exp 0", m, od[m]); end
            checks++; if ({opc[m], oa[m], ob[m]} !== 96'd0) begin errors++; $display("FAIL reset_data m=%0d got %h/%h/%h exp 0", m, opc[m], oa[m], ob[m]); end
            checks++; if (rv[m] !== 1'b0 || rpc[m] !== 32'd0) begin errors++; $display("FAIL reset_redirect m=%0d got %0b/%h exp 0/0", m, rv[m], rpc[m]); end
            checks++; if (scnt[m] !== 16'd0) begin errors++; $display("FAIL reset_stall m=%0d got %0d exp 0", m, scnt[m]); end
        end
        rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_straight();
        logic [31:0] ins;
        logic [31:0] av;
        for (int i = 0; i < 4; i++) begin
            ins = r_type(6'h20, 5'(1 + i), 5'(2 + i), 5'(3 + i));
            av  = $urandom;
            in_valid = 1'b1; in_pc = 32'(i * 4); in_instr = ins; a_gpr = av; b_gpr = $urandom;
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++; if (rs_o[m] !== 5'(1 + i) || rt_o[m] !== 5'(2 + i)) begin errors++; $display("FAIL straight_rsrt m=%0d got %0d/%0d exp %0d/%0d", m, rs_o[m], rt_o[m], 1 + i, 2 + i); end
                checks++; if (obs_rdy[m] !== 1'b1) begin errors++; $display("FAIL straight_ready m=%0d i=%0d got %0b exp 1", m, i, obs_rdy[m]); end
                checks++; if (ov[m] !== 1'b1 || opc[m] !== 32'(i * 4)) begin errors++; $display("FAIL straight_out m=%0d got v=%0b pc=%h exp v=1 pc=%h", m, ov[m], opc[m], i * 4); end
                checks++; if (od[m] !== ref_dec(ins) || oa[m] !== av) begin errors++; $display("FAIL straight_dec m=%0d got %h/%h exp %h/%h", m, od[m], oa[m], ref_dec(ins), av); end
                checks++; if (rv[m] !== 1'b0) begin errors++; $display("FAIL straight_redirect m=%0d got %0b exp 0", m, rv[m]); end
            end
        end
        idle();
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (ov[m] !== 1'b0) begin errors++; $display("FAIL straight_drain m=%0d got %0b exp 0", m, ov[m]); end
        end
    endtask

    task automatic test_load_use();
        idle();
        ex_load_valid = 1'b1; ex_load_rd = 5'd5;
        in_valid = 1'b1; in_pc = 32'h20; in_instr = r_type(6'h20, 5'd5, 5'd6, 5'd7);
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++; if (obs_rdy[m] !== 1'b0 || ov[m] !== 1'b0) begin errors++; $display("FAIL loaduse_stall m=%0d k=%0d got rdy=%0b v=%0b exp 0/0", m, k, obs_rdy[m], ov[m]); end
                checks++; if (scnt[m] !== 16'(k + 1)) begin errors++; $display("FAIL loaduse_cnt m=%0d got %0d exp %0d", m, scnt[m], k + 1); end
            end
        end
        ex_load_valid = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (obs_rdy[m] !== 1'b1 || ov[m] !== 1'b1 || opc[m] !== 32'h20) begin errors++; $display("FAIL loaduse_accept m=%0d got rdy=%0b v=%0b pc=%h exp 1/1/20", m, obs_rdy[m], ov[m], opc[m]); end
            checks++; if (scnt[m] !== 16'd3) begin errors++; $display("FAIL loaduse_cnt3 m=%0d got %0d exp 3", m, scnt[m]); end
        end
        ex_load_valid = 1'b1; ex_load_rd = 5'd0; in_pc = 32'h24; in_instr = r_type(6'h20, 5'd0, 5'd0, 5'd7);
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (obs_rdy[m] !== 1'b1 || opc[m] !== 32'h24 || scnt[m] !== 16'd3) begin errors++; $display("FAIL loaduse_r0 m=%0d got rdy=%0b pc=%h cnt=%0d exp 1/24/3", m, obs_rdy[m], opc[m], scnt[m]); end
        end
        ex_load_rd = 5'd6; in_pc = 32'h28; in_instr = r_type(6'h22, 5'd1, 5'd6, 5'd2);
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (obs_rdy[m] !== 1'b0 || scnt[m] !== 16'd4) begin errors++; $display("FAIL loaduse_rt m=%0d got rdy=%0b cnt=%0d exp 0/4", m, obs_rdy[m], scnt[m]); end
        end
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] i0, i1, a0, a1;
        i0 = i_type(6'h08, 5'd1, 5'd2, 16'($urandom)); a0 = $urandom;
        i1 = i_type(6'h23, 5'd3, 5'd4, 16'($urandom)); a1 = ~a0;
        idle();
        in_valid = 1'b1; in_pc = 32'h40; in_instr = i0; a_gpr = a0;
        tick();
        in_pc = 32'h44; in_instr = i1; a_gpr = a1; out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++; if (obs_rdy[m] !== 1'b0) begin errors++; $display("FAIL bp_ready m=%0d got %0b exp 0", m, obs_rdy[m]); end
                checks++; if (ov[m] !== 1'b1 || opc[m] !== 32'h40 || od[m] !== ref_dec(i0) || oa[m] !== a0) begin errors++; $display("FAIL bp_hold m=%0d got v=%0b pc=%h dec=%h a=%h exp 1/40/%h/%h", m, ov[m], opc[m], od[m], oa[m], ref_dec(i0), a0); end
            end
        end
        out_ready = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (obs_rdy[m] !== 1'b1 || opc[m] !== 32'h44 || od[m] !== ref_dec(i1) || oa[m] !== a1) begin errors++; $display("FAIL bp_release m=%0d got rdy=%0b pc=%h dec=%h exp 1/44/%h", m, obs_rdy[m], opc[m], od[m], ref_dec(i1)); end
        end
        idle();
        tick();
    endtask

    task automatic test_branch();
        logic [31:0] pcs [4];
        pcs[0] = 32'h14; pcs[1] = 32'h18; pcs[2] = 32'h100; pcs[3] = 32'h104;
        idle();
        in_valid = 1'b1; in_pc = 32'h10; in_instr = j_type(6'h02, 26'h40);
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (rv[m] !== 1'b1 || rpc[m] !== 32'h100) begin errors++; $display("FAIL branch_pulse m=%0d got %0b/%h exp 1/100", m, rv[m], rpc[m]); end
        end
        for (int i = 0; i < 4; i++) begin
            in_pc = pcs[i]; in_instr = r_type(6'h25, 5'd1, 5'd2, 5'd3);
            tick();
            checks++; if (rv[0] !== 1'b0 || rv[1] !== 1'b0) begin errors++; $display("FAIL branch_pulse_end i=%0d got %0b/%0b exp 0/0", i, rv[0], rv[1]); end
            checks++; if (ov[0] !== 1'b1 || opc[0] !== pcs[i]) begin errors++; $display("FAIL branch_slot_ds i=%0d got v=%0b pc=%h exp 1/%h", i, ov[0], opc[0], pcs[i]); end
            if (i < 2) begin
                checks++; if (obs_rdy[1] !== 1'b1 || ov[1] !== 1'b0) begin errors++; $display("FAIL branch_squash i=%0d got rdy=%0b v=%0b exp 1/0", i, obs_rdy[1], ov[1]); end
            end else begin
                checks++; if (ov[1] !== 1'b1 || opc[1] !== pcs[i]) begin errors++; $display("FAIL branch_target i=%0d got v=%0b pc=%h exp 1/%h", i, ov[1], opc[1], pcs[i]); end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_flush();
        int c0 [2];
        idle();
        in_valid = 1'b1; in_pc = 32'h10; in_instr = j_type(6'h02, 26'h40);
        tick();
        for (int m = 0; m < 2; m++) c0[m] = m_cnt[m];
        flush = 1'b1; in_pc = 32'h14; in_instr = r_type(6'h20, 5'd9, 5'd1, 5'd2);
        ex_load_valid = 1'b1; ex_load_rd = 5'd9;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (obs_rdy[m] !== 1'b0) begin errors++; $display("FAIL flush_ready m=%0d got %0b exp 0", m, obs_rdy[m]); end
            checks++; if (ov[m] !== 1'b0 || rv[m] !== 1'b0) begin errors++; $display("FAIL flush_kill m=%0d got v=%0b rv=%0b exp 0/0", m, ov[m], rv[m]); end
            checks++; if (scnt[m] !== 16'(c0[m])) begin errors++; $display("FAIL flush_stall m=%0d got %0d exp %0d", m, scnt[m], c0[m]); end
        end
        flush = 1'b0; ex_load_valid = 1'b0; in_pc = 32'h18;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (ov[m] !== 1'b1 || opc[m] !== 32'h18) begin errors++; $display("FAIL flush_resume m=%0d got v=%0b pc=%h exp 1/18", m, ov[m], opc[m]); end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_squash();
        idle();
        in_valid = 1'b1; in_pc = 32'h10; in_instr = j_type(6'h02, 26'h40);
        tick();
        idle(); rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b1; in_pc = 32'h14; in_instr = r_type(6'h24, 5'd1, 5'd2, 5'd3);
        tick();
        checks++; if (ov[1] !== 1'b1 || opc[1] !== 32'h14) begin errors++; $display("FAIL reset_squash got v=%0b pc=%h exp 1/14", ov[1], opc[1]); end
        idle();
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  s = 5'($urandom_range(0, 7));
        logic [4:0]  t = 5'($urandom_range(0, 7));
        logic [4:0]  d = 5'($urandom_range(0, 7));
        logic [15:0] imm = 16'($signed($urandom_range(0, 15)) - 8);
        case ($urandom_range(0, 9))
            0: return r_type(6'h20, s, t, d);
            1: return r_type(6'h22, s, t, d);
            2: return r_type(($urandom_range(0, 1) != 0) ? 6'h24 : 6'h25, s, t, d);
            3: return r_type(6'h08, s, t, 5'd0);
            4: return i_type(6'h08, s, t, imm);
            5: return i_type(6'h23, s, t, imm);
            6: return i_type(6'h2B, s, t, imm);
            7: return i_type(6'h04, s, t, imm);
            8: return i_type(6'h05, s, t, imm);
            default: return j_type(($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03, 26'($urandom_range(0, 255)));
        endcase
    endfunction

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = rand_instr();
            in_pc = ($urandom_range(0, 1) != 0) ? m_tgt[1] : 32'($urandom_range(0, 255)) << 2;
            a_gpr = $urandom_range(0, 3);
            b_gpr = ($urandom_range(0, 1) != 0) ? a_gpr : $urandom_range(0, 3);
            ex_load_valid = ($urandom_range(0, 2) == 0);
            ex_load_rd = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++; if (obs_rdy[m] !== e_rdy[m]) begin errors++; $display("FAIL rnd_ready n=%0d m=%0d got %0b exp %0b", n, m, obs_rdy[m], e_rdy[m]); end
                checks++; if (ov[m] !== m_valid[m]) begin errors++; $display("FAIL rnd_valid n=%0d m=%0d got %0b exp %0b", n, m, ov[m], m_valid[m]); end
                checks++; if (od[m] !== m_dec[m]) begin errors++; $display("FAIL rnd_dec n=%0d m=%0d got %h exp %h", n, m, od[m], m_dec[m]); end
                checks++; if (opc[m] !== m_pc[m]) begin errors++; $display("FAIL rnd_pc n=%0d m=%0d got %h exp %h", n, m, opc[m], m_pc[m]); end
                checks++; if (oa[m] !== m_a[m] || ob[m] !== m_b[m]) begin errors++; $display("FAIL rnd_ops n=%0d m=%0d got %h/%h exp %h/%h", n, m, oa[m], ob[m], m_a[m], m_b[m]); end
                checks++; if (rv[m] !== m_rv[m]) begin errors++; $display("FAIL rnd_rv n=%0d m=%0d got %0b exp %0b", n, m, rv[m], m_rv[m]); end
                checks++; if (rpc[m] !== m_rpc[m]) begin errors++; $display("FAIL rnd_rpc n=%0d m=%0d got %h exp %h", n, m, rpc[m], m_rpc[m]); end
                checks++; if (scnt[m] !== 16'(m_cnt[m])) begin errors++; $display("FAIL rnd_stall n=%0d m=%0d got %0d exp %0d", n, m, scnt[m], m_cnt[m]); end
            end
        end
        rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_saturate();
        idle();
        ex_load_valid = 1'b1; ex_load_rd = 5'd5;
        in_valid = 1'b1; in_pc = 32'h200; in_instr = r_type(6'h20, 5'd5, 5'd1, 5'd2);
        for (int k = 0; k < 65540; k++) tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (scnt[m] !== 16'hFFFF) begin errors++; $display("FAIL saturate m=%0d got %h exp ffff", m, scnt[m]); end
            checks++; if (obs_rdy[m] !== 1'b0) begin errors++; $display("FAIL saturate_ready m=%0d got %0b exp 0", m, obs_rdy[m]); end
        end
        idle();
        tick();
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0; m_dec[m] = '0; m_pc[m] = '0; m_a[m] = '0; m_b[m] = '0;
            m_rv[m] = 1'b0; m_rpc[m] = '0; m_cnt[m] = 0; m_sq[m] = 1'b0; m_tgt[m] = '0;
        end
        rst_n = 1'b0;
        test_reset();
        test_straight();
        test_load_use();
        test_backpressure();
        test_branch();
        test_flush();
        test_reset_mid_squash();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
